// File: rtl/fm_bus_pkg.sv
// Shared types and constants for the FM synth register-bus initiator.
package fm_bus_pkg;

  localparam int unsigned FM_ADDR_W = 6;
  localparam int unsigned FM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } fm_state_e;

  typedef struct packed {
    logic                 rw;
    logic [FM_ADDR_W-1:0] addr;
    logic [FM_DATA_W-1:0] wdata;
  } fm_cmd_t;

  function automatic int unsigned fm_max3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fm_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry one wrap bit.
module fm_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fm_bus_master.sv
// FM synth register-bus initiator: queues commands and plays each one out as a
// timed SETUP/STROBE/HOLD bus cycle with registered bus pins.
module fm_bus_master
  import fm_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rw,
  input  logic [FM_ADDR_W-1:0] cmd_addr,
  input  logic [FM_DATA_W-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_rw,
  output logic [FM_DATA_W-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 ceb_o,
  output logic                 rwb_o,
  output logic [FM_ADDR_W-1:0] addr_o,
  output logic [FM_DATA_W-1:0] bus_out,
  output logic                 bus_oe,
  input  logic [FM_DATA_W-1:0] bus_in
);

  localparam int unsigned CNT_W = $clog2(fm_max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;

  fm_state_e            r_state;
  fm_state_e            w_state_nx;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nx;
  logic                 w_last;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  fm_cmd_t              w_cmd_in;
  fm_cmd_t              w_head;
  logic                 r_ceb;
  logic                 r_rwb;
  logic                 r_oe;
  logic [FM_ADDR_W-1:0] r_addr;
  logic [FM_DATA_W-1:0] r_bus_out;
  logic                 r_rsp_valid;
  logic                 r_rsp_rw;
  logic [FM_DATA_W-1:0] r_rdata;

  assign w_cmd_in = {cmd_rw, cmd_addr, cmd_wdata};
  assign w_push   = cmd_valid & ~w_full;
  assign w_last   = (r_cnt == '0);

  fm_cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(fm_cmd_t))
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (w_cmd_in),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // One shared down-counter; each timed state loads its own length minus one.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pop      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = ST_SETUP;
          w_cnt_nx   = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (w_last) begin
          w_state_nx = ST_STROBE;
          w_cnt_nx   = CNT_W'(STROBE_CYC - 1);
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (w_last) begin
          w_state_nx = ST_HOLD;
          w_cnt_nx   = CNT_W'(HOLD_CYC - 1);
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (w_last) w_state_nx = ST_IDLE;
        else        w_cnt_nx   = r_cnt - CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ceb       <= 1'b1;
      r_rwb       <= 1'b1;
      r_oe        <= 1'b0;
      r_addr      <= '0;
      r_bus_out   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rw    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_ceb       <= (w_state_nx != ST_STROBE);
      r_rsp_valid <= 1'b0;
      if (w_pop) begin
        r_addr    <= w_head.addr;
        r_rwb     <= w_head.rw;
        r_bus_out <= w_head.wdata;
        r_oe      <= ~w_head.rw;
      end
      if (r_state == ST_STROBE && w_last && r_rwb) r_rdata <= bus_in;
      // Completion releases the bus direction but leaves addr/data parked.
      if (r_state == ST_HOLD && w_last) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rw    <= r_rwb;
        r_rwb       <= 1'b1;
        r_oe        <= 1'b0;
      end
    end
  end

  assign cmd_ready = ~w_full;
  assign busy      = (r_state != ST_IDLE) | ~w_empty;
  assign ceb_o     = r_ceb;
  assign rwb_o     = r_rwb;
  assign bus_oe    = r_oe;
  assign addr_o    = r_addr;
  assign bus_out   = r_bus_out;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rw    = r_rsp_rw;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_fm_bus_master.sv
// Bench for fm_bus_master: transaction-phase reference model plus directed vectors.
`timescale 1ns/1ps
module tb_fm_bus_master;

  localparam int S = 1, T = 2, H = 1, L = S + T + H, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT A (default timing)
  logic       rst_a = 1'b0, a_valid = 1'b0, a_rw = 1'b0;
  logic [5:0] a_addr = '0;
  logic [7:0] a_wdata = '0, dev_data = '0;
  logic       a_ready, a_rspv, a_rsprw, a_busy, a_ceb, a_rwb, a_oe;
  logic [7:0] a_rdata, a_bout, a_bin;
  logic [5:0] a_addro;
  assign a_bin = a_ceb ? 8'hFF : dev_data;

  fm_bus_master u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_rw(a_rw), .cmd_addr(a_addr), .cmd_wdata(a_wdata),
    .rsp_valid(a_rspv), .rsp_rw(a_rsprw), .rsp_rdata(a_rdata), .busy(a_busy),
    .ceb_o(a_ceb), .rwb_o(a_rwb), .addr_o(a_addro), .bus_out(a_bout),
    .bus_oe(a_oe), .bus_in(a_bin)
  );

  // DUT B (SETUP=2, STROBE=1, HOLD=3)
  logic       rst_b = 1'b0, b_valid = 1'b0, b_rw = 1'b0, b_arm = 1'b0;
  logic [5:0] b_addr = '0;
  logic [7:0] b_wdata = '0, bus_in_b = 8'h11;
  logic       b_ready, b_rspv, b_rsprw, b_busy, b_ceb, b_rwb, b_oe;
  logic [7:0] b_rdata, b_bout;
  logic [5:0] b_addro;

  fm_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .FIFO_DEPTH(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_rw(b_rw), .cmd_addr(b_addr), .cmd_wdata(b_wdata),
    .rsp_valid(b_rspv), .rsp_rw(b_rsprw), .rsp_rdata(b_rdata), .busy(b_busy),
    .ceb_o(b_ceb), .rwb_o(b_rwb), .addr_o(b_addro), .bus_out(b_bout),
    .bus_oe(b_oe), .bus_in(bus_in_b)
  );

  // Device model for B: read data changes one cycle after CEb falls.
  always @(posedge clk) begin
    if (b_arm && !b_ceb) begin
      #1 bus_in_b = 8'h22;
      b_arm = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: queue of commands, and the phase number (1..L) of the
  // transaction in flight, 0 when idle.
  typedef struct { logic rw; logic [5:0] addr; logic [7:0] wdata; } mcmd_t;
  mcmd_t      q[$];
  mcmd_t      cur = '{1'b0, 6'h0, 8'h0};
  mcmd_t      newc;
  int         ph = 0;
  logic [5:0] m_addr = '0;
  logic [7:0] m_bout = '0, m_rdata = '0;
  logic       m_rspv = 1'b0, m_rsprw = 1'b0, m_acc;
  logic       mchk = 1'b0;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      q.delete();
      ph = 0; m_addr = '0; m_bout = '0; m_rdata = '0; m_rspv = 1'b0; m_rsprw = 1'b0;
    end else begin
      m_acc  = a_valid && (q.size() < DEPTH);
      newc   = '{a_rw, a_addr, a_wdata};
      m_rspv = 1'b0;
      if (ph == 0) begin
        if (q.size() != 0) begin
          cur = q.pop_front();
          ph = 1; m_addr = cur.addr; m_bout = cur.wdata;
        end
      end else if (ph == L) begin
        ph = 0; m_rspv = 1'b1; m_rsprw = cur.rw;
      end else begin
        if (ph == S + T && cur.rw) m_rdata = a_bin;
        ph++;
      end
      if (m_acc) q.push_back(newc);
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      chk("a.cmd_ready", a_ready, q.size() < DEPTH);
      chk("a.busy", a_busy, (ph != 0) || (q.size() != 0));
      chk("a.ceb", a_ceb, !(ph > S && ph <= S + T));
      chk("a.rwb", a_rwb, (ph != 0) ? cur.rw : 1'b1);
      chk("a.bus_oe", a_oe, (ph != 0) && !cur.rw);
      chk("a.addr", a_addro, m_addr);
      chk("a.bus_out", a_bout, m_bout);
      chk("a.rsp_valid", a_rspv, m_rspv);
      chk("a.rsp_rdata", a_rdata, m_rdata);
      if (m_rspv) chk("a.rsp_rw", a_rsprw, m_rsprw);
    end
  end

  int   mon_cyc[$];
  logic mon_rw[$];
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && a_rspv) begin
      mon_cyc.push_back(cyc);
      mon_rw.push_back(a_rsprw);
    end
  end

  typedef struct {
    logic rw; logic [5:0] addr; logic [7:0] wdata; logic [7:0] rin; logic [7:0] exp_rdata;
  } vec_t;
  vec_t tv[6];

  task automatic wait_idle_a();
    int n = 0;
    @(negedge clk);
    while (a_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (a_busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", a_busy, n);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wait_idle_a();
    a_valid = 1'b1; a_rw = v.rw; a_addr = v.addr; a_wdata = v.wdata; dev_data = v.rin;
    @(negedge clk);
    a_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        chk($sformatf("vec%0d.addr k%0d", idx, k), a_addro, v.addr);
        chk($sformatf("vec%0d.rwb k%0d", idx, k), a_rwb, v.rw);
        chk($sformatf("vec%0d.oe k%0d", idx, k), a_oe, !v.rw);
        if (!v.rw) chk($sformatf("vec%0d.bus_out k%0d", idx, k), a_bout, v.wdata);
        chk($sformatf("vec%0d.ceb k%0d", idx, k), a_ceb, !(k == 2 || k == 3));
      end
      chk($sformatf("vec%0d.rsp_valid k%0d", idx, k), a_rspv, k == 5);
      if (k == 5) begin
        chk($sformatf("vec%0d.rsp_rw", idx), a_rsprw, v.rw);
        chk($sformatf("vec%0d.rsp_rdata", idx), a_rdata, v.exp_rdata);
      end
    end
  endtask

  task automatic six_cmd();
    int acc = 0, at_fall = -1, n = 0;
    logic r;
    logic [0:5] rwpat = 6'b011010;
    wait_idle_a();
    mon_cyc.delete(); mon_rw.delete(); mon_en = 1'b1;
    a_valid = 1'b1;
    while (acc < 6 && n < 60) begin
      a_rw = rwpat[acc]; a_addr = 6'(acc + 8); a_wdata = 8'(acc + 8'h40);
      dev_data = 8'($urandom);
      r = a_ready;
      if (!r && at_fall < 0) at_fall = acc;
      @(negedge clk);
      n++;
      if (r) acc++;
    end
    a_valid = 1'b0;
    chk("six.accepts", acc, 6);
    chk("six.ready_fall_after", at_fall, 5);
    wait_idle_a();
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("six.rsp_count", mon_cyc.size(), 6);
    for (int i = 0; i < 6 && i < mon_cyc.size(); i++) begin
      chk($sformatf("six.rsp_rw%0d", i), mon_rw[i], rwpat[i]);
      if (i > 0) chk($sformatf("six.spacing%0d", i), mon_cyc[i] - mon_cyc[i-1], 5);
    end
  endtask

  task automatic reset_test();
    int lows = 0, rsps = 0, busys = 0;
    wait_idle_a();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_rw = (i == 0) ? 1'b0 : i[0]; a_addr = 6'(16 + i);
      a_wdata = 8'(8'hC0 + i);
      @(negedge clk);
    end
    a_valid = 1'b0;
    chk("rst.pre_ceb", a_ceb, 0);
    chk("rst.pre_busy", a_busy, 1);
    #2 rst_a = 1'b1;
    #1;
    chk("rst.ceb", a_ceb, 1);
    chk("rst.bus_oe", a_oe, 0);
    chk("rst.busy", a_busy, 0);
    chk("rst.ready", a_ready, 1);
    chk("rst.rwb", a_rwb, 1);
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!a_ceb) lows++;
      if (a_rspv) rsps++;
      if (a_busy) busys++;
    end
    chk("rst.post_strobes", lows, 0);
    chk("rst.post_rsp", rsps, 0);
    chk("rst.post_busy", busys, 0);
  endtask

  task automatic random_test();
    for (int c = 0; c < 400; c++) begin
      a_valid  = ($urandom_range(0, 99) < 60);
      a_rw     = 1'($urandom_range(0, 1));
      a_addr   = 6'($urandom);
      a_wdata  = 8'($urandom);
      dev_data = 8'($urandom);
      @(negedge clk);
    end
    a_valid = 1'b0;
    wait_idle_a();
    repeat (2) @(negedge clk);
  endtask

  task automatic dut_b_test();
    int busy_n = 0, low_n = 0, low_k = -1, rsp_k = -1;
    @(negedge clk);
    b_valid = 1'b1; b_rw = 1'b1; b_addr = 6'h2C; b_wdata = 8'h00;
    bus_in_b = 8'h11; b_arm = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (b_busy) busy_n++;
      if (!b_ceb) begin low_n++; low_k = k; end
      chk($sformatf("b.rwb k%0d", k), b_rwb, 1);
      chk($sformatf("b.oe k%0d", k), b_oe, 0);
      if (b_rspv) begin
        rsp_k = k;
        chk("b.rsp_rdata", b_rdata, 8'h11);
        chk("b.rsp_rw", b_rsprw, 1);
      end
      @(negedge clk);
    end
    chk("b.busy_cycles", busy_n, 7);
    chk("b.strobe_cycles", low_n, 1);
    chk("b.strobe_at", low_k, 3);
    chk("b.rsp_at", rsp_k, 7);
    chk("b.addr", b_addro, 6'h2C);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1'b0, 6'h05, 8'hA5, 8'h5A, 8'h00};
    tv[1] = '{1'b1, 6'h3F, 8'h00, 8'h5A, 8'h5A};
    tv[2] = '{1'b0, 6'h2A, 8'h3C, 8'h77, 8'h5A};
    tv[3] = '{1'b1, 6'h00, 8'hFF, 8'hC3, 8'hC3};
    tv[4] = '{1'b1, 6'h15, 8'h00, 8'h00, 8'h00};
    tv[5] = '{1'b0, 6'h3F, 8'hFF, 8'h99, 8'h00};

    #1 rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    mchk = 1'b1;
    chk("a.rst.rsp_rw", a_rsprw, 0);
    chk("b.rst.ready", b_ready, 1);
    chk("b.rst.ceb", b_ceb, 1);
    chk("b.rst.rwb", b_rwb, 1);
    chk("b.rst.oe", b_oe, 0);
    chk("b.rst.busy", b_busy, 0);
    chk("b.rst.rspv", b_rspv, 0);
    chk("b.rst.rsp_rw", b_rsprw, 0);
    chk("b.rst.rdata", b_rdata, 0);
    chk("b.rst.addr", b_addro, 0);
    chk("b.rst.bus_out", b_bout, 0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tv[i], i);
    six_cmd();
    reset_test();
    random_test();
    dut_b_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_bus_master.md
# fm_bus_master

Host-side initiator for the FM synth register bus. It accepts register read/write commands on a valid/ready interface and queues them in a small FIFO. Each command becomes one timed bus cycle on the synth's chip-enable (CEb), read/write (RWb), 6-bit address and 8-bit data lines, and read data is returned on a response port. It sits in the controller/test-harness domain and drives the synth's bus pins directly.

## Interface
- SETUP_CYC, 1: cycles address/RWb/write data are stable before CEb falls (≥1)
- STROBE_CYC, 2: cycles CEb is held low (≥1)
- HOLD_CYC, 1: cycles address/RWb/write data are held after CEb rises (≥1)
- FIFO_DEPTH, 4: command FIFO entries (power of 2, ≥2)
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_rw  in  1  1 = read, 0 = write
- cmd_addr  in  6  register address
- cmd_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse, transaction complete
- rsp_rw  out  1  type of the completed transaction
- rsp_rdata  out  8  last read data; updated only by reads
- busy  out  1  a transaction is in progress or the FIFO is non-empty
- ceb_o  out  1  bus chip enable, active-low
- rwb_o  out  1  bus read/write; 1 = read
- addr_o  out  6  bus address
- bus_out  out  8  bus write data
- bus_oe  out  1  1 = master drives the data bus
- bus_in  in  8  bus read data

## Operation
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rw=0, rsp_rdata=0, busy=0, ceb_o=1, rwb_o=1, addr_o=0, bus_out=0, bus_oe=0; FIFO empty; state IDLE.
- cmd_ready = FIFO not full. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD. All bus outputs are registered.
  - IDLE: ceb_o=1, rwb_o=1, bus_oe=0. If the FIFO is non-empty: pop the head, load addr_o/rwb_o/bus_out, set bus_oe = !rw, go to SETUP.
  - SETUP: ceb_o=1, bus signals stable. Stays SETUP_CYC cycles, then STROBE.
  - STROBE: ceb_o=0. Stays STROBE_CYC cycles. For reads, bus_in is captured into rsp_rdata on the edge that ends the last STROBE cycle. Then HOLD.
  - HOLD: ceb_o=1; addr_o, rwb_o, bus_out and bus_oe are unchanged. Stays HOLD_CYC cycles, then IDLE with rsp_valid=1 and rsp_rw set for that one cycle.
- On leaving HOLD, rwb_o returns to 1 and bus_oe to 0. addr_o and bus_out keep their last values.
- Every transaction has at least one IDLE cycle before the next SETUP.
- A single down-counter, width clog2(max param)+1, times the SETUP, STROBE and HOLD states.
- Commands complete strictly in FIFO order. There is no response backpressure; rsp_valid is a pulse.
- busy = (state != IDLE) | FIFO non-empty.
- Asynchronous reset in any state immediately forces all outputs to their reset values and discards queued commands. There is no partial-cycle completion and no rsp_valid.

## Timing
- Push at edge E into an empty FIFO while IDLE: the FIFO is non-empty from E. IDLE pops at edge E+1, so SETUP is visible in cycle E+1..E+1+SETUP_CYC.
- Transaction length: SETUP_CYC + STROBE_CYC + HOLD_CYC cycles, plus 1 IDLE cycle.
  - With defaults: 4 bus cycles, and rsp_valid is high 5 cycles after the push edge.
  - Back-to-back throughput: one transaction per 5 cycles.
- rsp_rdata is valid no later than rsp_valid and holds until the next read completes.
- No combinational path from bus_in to any output. bus_in is sampled once per read.

## Structure
- Package fm_bus_pkg holds FM_ADDR_W=6, FM_DATA_W=8, the FSM state enum, and the command struct {rw, addr, wdata}.
- One sub-module, fm_cmd_fifo: a synchronous FIFO parameterized by depth and the command-struct width, with full/empty flags and an async active-high reset.

## Test plan
- Write addr=0x05, data=0xA5, defaults:
  - addr_o=0x05, rwb_o=0, bus_oe=1, bus_out=0xA5 for 4 cycles.
  - ceb_o=0 only during cycles 2–3 of those 4.
  - rsp_valid pulses once with rsp_rw=0; rsp_rdata stays 0.
- Read addr=0x3F, bus_in=0x5A during STROBE (0xFF at all other times):
  - rwb_o=1, bus_oe=0 throughout.
  - rsp_rdata=0x5A at the rsp_valid pulse, with rsp_rw=1.
- Push 6 commands with cmd_valid held high while the FSM is busy:
  - cmd_ready falls after 5 accepts (4 queued + 1 in flight) and the 6th is refused until a pop.
  - All 6 complete in order with 5-cycle spacing.
- Assert rst_i mid-STROBE of a write with 3 commands queued:
  - ceb_o=1, bus_oe=0 and busy=0 in the same cycle.
  - No rsp_valid pulse; no queued command executes after release.
- SETUP_CYC=2, STROBE_CYC=1, HOLD_CYC=3, read with bus_in changing from 0x11 to 0x22 one cycle after the strobe edge:
  - rsp_rdata=0x11.
  - Transaction spans 6 bus cycles + 1 IDLE.
